// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider producing one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to enable two's-complement operation through is_signed.

module seq_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;

    logic             accept;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] res_quo, res_rem;

    assign accept = start && (state_q != S_RUN);

    // One restoring step; a set shifted-out MSB guarantees the subtract succeeds.
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign ge       = rem_sh[WIDTH] | ~trial[WIDTH];
    assign rem_step = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_step = {dvd_q[WIDTH-2:0], ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_dvd_q, neg_dvs_q;

    // Operand signs captured with the operands; they steer magnitude and fix-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
        end else if (accept) begin
            neg_dvd_q <= is_signed & dividend[WIDTH-1];
            neg_dvs_q <= is_signed & divisor[WIDTH-1];
        end
    end

    assign mag_dvd = neg_dvd_q ? WIDTH'(0) - dvd_q : dvd_q;
    assign mag_dvs = neg_dvs_q ? WIDTH'(0) - dvs_q : dvs_q;
    assign res_quo = (neg_dvd_q ^ neg_dvs_q) ? WIDTH'(0) - quo_step : quo_step;
    assign res_rem = neg_dvd_q ? WIDTH'(0) - rem_step : rem_step;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_dvd = dvd_q;
    assign mag_dvs = dvs_q;
    assign res_quo = quo_step;
    assign res_rem = rem_step;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    // First RUN cycle conditions operands, then WIDTH shift-subtract iterations.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;

        case (state_q)
            S_RUN: begin
                if (load_q) begin
                    dvd_d  = mag_dvd;
                    dvs_d  = mag_dvs;
                    rem_d  = '0;
                    load_d = 1'b0;
                end else begin
                    dvd_d = quo_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        quo_d   = res_quo;
                        rmd_d   = res_rem;
                        dbz_d   = 1'b0;
                    end
                end
            end
            default: begin
                if (accept) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    cnt_d = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        load_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider against an arithmetic reference model.
// Signed cases are exercised when SEQ_DIVIDER_SIGNED_EN is defined.

module tb_seq_divider;

    localparam int unsigned W = 64;
    localparam int          LAT = W + 1;
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, is_signed;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    logic         busy, done, div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .is_signed  (is_signed),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Reference: plain integer division with the documented corner cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        longint sa, sb;
        sa  = a;
        sb  = b;
        dz  = (b == '0);
        lat = dz ? 0 : LAT;
        if (dz) begin
            q = '1;
            r = a;
        end else if (s && SIGNED_BUILD) begin
            if (a == MIN_V && sb == -1) begin
                q = MIN_V;
                r = '0;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return v;
            1:       return W'($urandom_range(1, 255));
            2:       return v >> $urandom_range(0, W - 1);
            default: return v >> $urandom_range(W / 2, W - 1);
        endcase
    endfunction

    // Drives one request and returns edges from accept to DONE entry (-1 if none).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat, output int bcnt);
        int e;
        bit got;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e = 0; got = 1'b0; bcnt = 0; lat = -1;
        q = '0; r = '0; dz = 1'b0;
        while (!got && e <= 200) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                got = 1'b1; lat = e;
                q = quotient; r = remainder; dz = div_by_zero;
            end else begin
                @(posedge clk);
                e++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b, want 0 0", busy, done);
        end
        checks++;
        if ({div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_results: q=%h r=%h dz=%b, want all 0", quotient, remainder, div_by_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] av [3], bv [3], eq [3], er [3];
        logic         edz [3];
        int           elat [3];
        logic [W-1:0] q, r;
        logic         dz;
        int           lat, bcnt;
        av[0] = W'(57);  bv[0] = W'(8);  eq[0] = W'(7); er[0] = W'(1);    edz[0] = 1'b0; elat[0] = LAT;
        av[1] = '1;      bv[1] = MIN_V;  eq[1] = W'(1); er[1] = ~MIN_V;   edz[1] = 1'b0; elat[1] = LAT;
        av[2] = W'(100); bv[2] = '0;     eq[2] = '1;    er[2] = W'(100);  edz[2] = 1'b1; elat[2] = 0;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], 1'b0, q, r, dz, lat, bcnt);
            checks++;
            if ({q, r, dz, lat} !== {eq[i], er[i], edz[i], elat[i]}) begin
                errors++;
                $display("FAIL directed_%0d: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         i, q, r, dz, lat, eq[i], er[i], edz[i], elat[i]);
            end
            checks++;
            if (bcnt != elat[i]) begin
                errors++;
                $display("FAIL busy_cycles_%0d: got %0d, want %0d", i, bcnt, elat[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_%0d: done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic random_ops(input string name, input logic s, input int n);
        logic [W-1:0] a, b, q, r, eq, er;
        logic         dz, edz;
        int           lat, elat, bcnt;
        for (int i = 0; i < n; i++) begin
            a = rnd_op();
            b = ($urandom_range(0, 9) == 0) ? '0 : rnd_op();
            if (s && $urandom_range(0, 1) == 1) a = W'(0) - a;
            if (s && $urandom_range(0, 1) == 1) b = W'(0) - b;
            model(a, b, s, eq, er, edz, elat);
            run_op(a, b, s, q, r, dz, lat, bcnt);
            checks++;
            if ({q, r, dz, lat} !== {eq, er, edz, elat}) begin
                errors++;
                $display("FAIL %s_%0d: a=%h b=%h got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         name, i, a, b, q, r, dz, lat, eq, er, edz, elat);
            end
        end
    endtask

    task automatic test_random_unsigned();
        random_ops("rand_unsigned", 1'b0, 40);
    endtask

    task automatic test_signed();
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic [W-1:0] av [4], bv [4], eq [4], er [4];
        logic         edz [4];
        logic [W-1:0] q, r;
        logic         dz;
        int           lat, bcnt;
        av[0] = W'(-57); bv[0] = W'(8);   eq[0] = W'(-7); er[0] = W'(-1); edz[0] = 1'b0;
        av[1] = W'(57);  bv[1] = W'(-8);  eq[1] = W'(-7); er[1] = W'(1);  edz[1] = 1'b0;
        av[2] = MIN_V;   bv[2] = W'(-1);  eq[2] = MIN_V;  er[2] = '0;     edz[2] = 1'b0;
        av[3] = W'(-5);  bv[3] = '0;      eq[3] = '1;     er[3] = W'(-5); edz[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(av[i], bv[i], 1'b1, q, r, dz, lat, bcnt);
            checks++;
            if ({q, r, dz, lat} !== {eq[i], er[i], edz[i], (edz[i] ? 0 : LAT)}) begin
                errors++;
                $display("FAIL signed_%0d: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b",
                         i, q, r, dz, lat, eq[i], er[i], edz[i]);
            end
        end
        random_ops("rand_signed", 1'b1, 30);
`else
        random_ops("is_signed_ignored", 1'b1, 20);
`endif
    endtask

    task automatic test_start_during_run();
        logic [W-1:0] a, b, q, r, eq, er;
        logic         dz, edz;
        int           lat, elat, e;
        bit           got;
        a = rnd_op() | MIN_V;
        b = W'($urandom_range(2, 1000));
        model(a, b, 1'b0, eq, er, edz, elat);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e = 0; got = 1'b0; lat = -1; q = '0; r = '0; dz = 1'b0;
        while (!got && e <= 200) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1; lat = e;
                q = quotient; r = remainder; dz = div_by_zero;
            end else begin
                start    = (e >= 3 && e <= 8);
                dividend = ~a;
                divisor  = W'(3);
                @(posedge clk);
                e++;
            end
        end
        start = 1'b0;
        checks++;
        if ({q, r, dz, lat} !== {eq, er, edz, elat}) begin
            errors++;
            $display("FAIL start_in_run: got q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                     q, r, dz, lat, eq, er, edz, elat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] q, r;
        logic         dz;
        int           lat, bcnt;
        bit           seen;
        @(negedge clk);
        dividend = {$urandom, $urandom} | MIN_V; divisor = W'(13); is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_run_flags: busy=%b done=%b, want 0 0", busy, done);
        end
        checks++;
        if ({div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run_results: q=%h r=%h dz=%b, want all 0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_run_no_done: done seen=%b, want 0", seen);
        end
        run_op(W'(1000), W'(7), 1'b0, q, r, dz, lat, bcnt);
        checks++;
        if ({q, r, dz, lat} !== {W'(142), W'(6), 1'b0, LAT}) begin
            errors++;
            $display("FAIL first_after_reset: got q=%h r=%h dz=%b lat=%0d, want q=142 r=6 dz=0 lat=%0d",
                     q, r, dz, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, q1, r1, q2, r2, eq1, er1, eq2, er2;
        logic         edz;
        int           elat, e, d1, d2;
        a1 = rnd_op(); b1 = rnd_op() | W'(1);
        a2 = rnd_op(); b2 = rnd_op() | W'(2);
        model(a1, b1, 1'b0, eq1, er1, edz, elat);
        model(a2, b2, 1'b0, eq2, er2, edz, elat);
        @(negedge clk);
        dividend = a1; divisor = b1; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 dividend = a2; divisor = b2;
        e = 0; d1 = -1; d2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        while (d2 < 0 && e < 400) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = e; q1 = quotient; r1 = remainder;
                end else begin
                    d2 = e; q2 = quotient; r2 = remainder;
                end
            end
            @(posedge clk);
            e++;
            if (d1 >= 0 && start) #1 start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if ({q1, r1, d1} !== {eq1, er1, LAT}) begin
            errors++;
            $display("FAIL b2b_first: got q=%h r=%h at edge %0d, want q=%h r=%h at edge %0d",
                     q1, r1, d1, eq1, er1, LAT);
        end
        checks++;
        if ({q2, r2, d2 - d1} !== {eq2, er2, LAT + 1}) begin
            errors++;
            $display("FAIL b2b_second: got q=%h r=%h gap %0d, want q=%h r=%h gap %0d",
                     q2, r2, d2 - d1, eq2, er2, LAT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_unsigned();
        test_signed();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
